// File: rtl/mc97_ctrl_pkg.sv
// Shared types and constants for the MC97 codec controller: FSM states and the
// codec init table contents.
package mc97_ctrl_pkg;

   typedef enum logic [2:0] {
      OFF,
      WAIT_RDY,
      INIT,
      IDLE,
      HOST,
      DRAIN,
      FAULT
   } state_e;

   localparam int unsigned INIT_LEN = 4;
   localparam int unsigned IDX_W    = $clog2(INIT_LEN);

   localparam logic [5:0]  INIT0_ADDR = 6'h00;
   localparam logic [15:0] INIT0_DATA = 16'h0000;
   localparam logic [5:0]  INIT1_ADDR = 6'h1F;
   localparam logic [15:0] INIT1_DATA = 16'h0000;
   localparam logic [5:0]  INIT2_ADDR = 6'h20;
   localparam logic [15:0] INIT2_DATA = 16'h1F40;
   localparam logic [5:0]  INIT3_ADDR = 6'h23;
   localparam logic [15:0] INIT3_DATA = 16'h0000;

endpackage

// File: rtl/mc97_ctrl_init_rom.sv
// Combinational codec init table: entry index -> register address and write data.
module mc97_ctrl_init_rom
   import mc97_ctrl_pkg::*;
(
   input  logic [IDX_W-1:0] idx_i,
   output logic [5:0]       addr_o,
   output logic [15:0]      data_o
);

   always_comb begin
      addr_o = '0;
      data_o = '0;
      case (idx_i)
         2'd0: begin addr_o = INIT0_ADDR; data_o = INIT0_DATA; end
         2'd1: begin addr_o = INIT1_ADDR; data_o = INIT1_DATA; end
         2'd2: begin addr_o = INIT2_ADDR; data_o = INIT2_DATA; end
         2'd3: begin addr_o = INIT3_ADDR; data_o = INIT3_DATA; end
      endcase
   end

endmodule

// File: rtl/mc97_ctrl.sv
// MC97 controller: codec bring-up, init table sequencing, host register access and watchdog.
// Defining MC97_CTRL_RETRY_EN adds automatic re-issue of host reads that return reg_rerr.
module mc97_ctrl
   import mc97_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_W = 20,
   parameter int unsigned RETRY_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [5:0]  h_addr,
   input  logic [15:0] h_wdata,
   input  logic        h_we,
   input  logic        h_valid,
   output logic [15:0] h_rdata,
   output logic        h_err,
   output logic        h_ack,
   output logic [5:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_we,
   output logic        reg_valid,
   input  logic [15:0] reg_rdata,
   input  logic        reg_rerr,
   input  logic        reg_ack,
   input  logic        stat_codec_ready,
   output logic        cfg_run,
   output logic        stat_ready,
   output logic        stat_fault
);

   state_e               state_q;
   logic [TIMEOUT_W-1:0] wd_q;
   logic [IDX_W-1:0]     idx_q;
   logic                 host_q;
   logic                 cfg_run_q, reg_valid_q, reg_we_q, h_ack_q, h_err_q;
   logic                 stat_ready_q, stat_fault_q;
   logic [5:0]           reg_addr_q;
   logic [15:0]          reg_wdata_q, h_rdata_q;
   logic [5:0]           rom_addr;
   logic [15:0]          rom_data;
   logic                 ack_ok, wd_exp, host_new, retry_go;

   // An ack with nothing outstanding (e.g. left over from before a reset) is ignored.
   assign ack_ok   = reg_ack & reg_valid_q;
   assign wd_exp   = (wd_q == '1);
   assign host_new = h_valid & ~h_ack_q;

   mc97_ctrl_init_rom u_rom (
      .idx_i  (idx_q),
      .addr_o (rom_addr),
      .data_o (rom_data)
   );

`ifdef MC97_CTRL_RETRY_EN
   localparam int unsigned RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
   logic [RETRY_W-1:0] retry_q;

   assign retry_go = (state_q == HOST) & ack_ok & ~reg_we_q & reg_rerr &
                     (retry_q < RETRY_W'(RETRY_MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         retry_q <= '0;
      end else if ((state_q == IDLE) && enable && host_new) begin
         retry_q <= '0;
      end else if (retry_go) begin
         retry_q <= retry_q + 1'b1;
      end
   end
`else
   logic unused_retry_max;
   assign unused_retry_max = (RETRY_MAX != 0);
   assign retry_go         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= OFF;
         wd_q         <= '0;
         idx_q        <= '0;
         host_q       <= 1'b0;
         cfg_run_q    <= 1'b0;
         reg_valid_q  <= 1'b0;
         reg_we_q     <= 1'b0;
         reg_addr_q   <= '0;
         reg_wdata_q  <= '0;
         h_ack_q      <= 1'b0;
         h_err_q      <= 1'b0;
         h_rdata_q    <= '0;
         stat_ready_q <= 1'b0;
         stat_fault_q <= 1'b0;
      end else begin
         h_ack_q <= 1'b0;
         wd_q    <= reg_ack ? '0 : wd_q + 1'b1;
         case (state_q)
            OFF: begin
               if (host_new) begin
                  h_ack_q <= 1'b1;
                  h_err_q <= 1'b1;
               end
               if (enable) begin
                  state_q   <= WAIT_RDY;
                  cfg_run_q <= 1'b1;
                  wd_q      <= '0;
               end
            end
            WAIT_RDY: begin
               if (!enable) begin
                  state_q   <= OFF;
                  cfg_run_q <= 1'b0;
                  wd_q      <= '0;
               end else if (stat_codec_ready) begin
                  state_q <= INIT;
                  idx_q   <= '0;
                  wd_q    <= '0;
               end else if (wd_exp) begin
                  state_q      <= FAULT;
                  stat_fault_q <= 1'b1;
                  wd_q         <= '0;
               end
            end
            INIT: begin
               if (!reg_valid_q) begin
                  if (!enable) begin
                     state_q   <= OFF;
                     cfg_run_q <= 1'b0;
                     wd_q      <= '0;
                  end else begin
                     reg_valid_q <= 1'b1;
                     reg_we_q    <= 1'b1;
                     reg_addr_q  <= rom_addr;
                     reg_wdata_q <= rom_data;
                     host_q      <= 1'b0;
                  end
               end else if (ack_ok) begin
                  reg_valid_q <= 1'b0;
                  if (!enable) begin
                     state_q   <= OFF;
                     cfg_run_q <= 1'b0;
                  end else if (idx_q == IDX_W'(INIT_LEN - 1)) begin
                     state_q      <= IDLE;
                     stat_ready_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else if (wd_exp) begin
                  reg_valid_q  <= 1'b0;
                  state_q      <= FAULT;
                  stat_fault_q <= 1'b1;
                  wd_q         <= '0;
               end else if (!enable) begin
                  state_q <= DRAIN;
                  wd_q    <= '0;
               end
            end
            IDLE: begin
               if (!enable) begin
                  state_q      <= OFF;
                  cfg_run_q    <= 1'b0;
                  stat_ready_q <= 1'b0;
                  wd_q         <= '0;
               end else if (host_new) begin
                  reg_addr_q   <= h_addr;
                  reg_wdata_q  <= h_wdata;
                  reg_we_q     <= h_we;
                  reg_valid_q  <= 1'b1;
                  host_q       <= 1'b1;
                  state_q      <= HOST;
                  stat_ready_q <= 1'b0;
                  wd_q         <= '0;
               end
            end
            HOST: begin
               if (ack_ok) begin
                  reg_valid_q <= 1'b0;
                  h_rdata_q   <= reg_rdata;
                  if (!retry_go) begin
                     h_ack_q <= 1'b1;
                     h_err_q <= ~reg_we_q & reg_rerr;
                     if (enable) begin
                        state_q      <= IDLE;
                        stat_ready_q <= 1'b1;
                     end else begin
                        state_q   <= OFF;
                        cfg_run_q <= 1'b0;
                     end
                  end
               end else if (!reg_valid_q) begin
                  // Gap cycle between a retried read's ack and its re-issue.
                  if (!enable) begin
                     state_q   <= OFF;
                     cfg_run_q <= 1'b0;
                     wd_q      <= '0;
                  end else begin
                     reg_valid_q <= 1'b1;
                  end
               end else if (wd_exp) begin
                  reg_valid_q <= 1'b0;
                  h_ack_q     <= 1'b1;
                  h_err_q     <= 1'b1;
                  wd_q        <= '0;
                  if (enable) begin
                     state_q      <= IDLE;
                     stat_ready_q <= 1'b1;
                  end else begin
                     state_q   <= OFF;
                     cfg_run_q <= 1'b0;
                  end
               end else if (!enable) begin
                  state_q <= DRAIN;
                  wd_q    <= '0;
               end
            end
            DRAIN: begin
               if (ack_ok || wd_exp) begin
                  reg_valid_q <= 1'b0;
                  state_q     <= OFF;
                  cfg_run_q   <= 1'b0;
                  wd_q        <= '0;
                  if (host_q) begin
                     h_ack_q   <= 1'b1;
                     h_err_q   <= ack_ok ? (~reg_we_q & reg_rerr) : 1'b1;
                     h_rdata_q <= ack_ok ? reg_rdata : h_rdata_q;
                  end
               end
            end
            FAULT: begin
               if (host_new) begin
                  h_ack_q <= 1'b1;
                  h_err_q <= 1'b1;
               end
               if (!enable) begin
                  state_q      <= OFF;
                  cfg_run_q    <= 1'b0;
                  stat_fault_q <= 1'b0;
                  wd_q         <= '0;
               end
            end
            default: state_q <= OFF;
         endcase
      end
   end

   assign h_rdata    = h_rdata_q;
   assign h_err      = h_err_q;
   assign h_ack      = h_ack_q;
   assign reg_addr   = reg_addr_q;
   assign reg_wdata  = reg_wdata_q;
   assign reg_we     = reg_we_q;
   assign reg_valid  = reg_valid_q;
   assign cfg_run    = cfg_run_q;
   assign stat_ready = stat_ready_q;
   assign stat_fault = stat_fault_q;

endmodule

// File: tb/tb_mc97_ctrl.sv
// Directed self-checking bench for mc97_ctrl: one default instance plus a TIMEOUT_W=6
// instance for watchdog expiry; retry checks depend on MC97_CTRL_RETRY_EN.
module tb_mc97_ctrl;

   logic        clk = 1'b0;
   logic        rst, enable, h_we, h_valid, reg_rerr, reg_ack, stat_codec_ready;
   logic [5:0]  h_addr;
   logic [15:0] h_wdata, reg_rdata;
   logic [15:0] h_rdata, reg_wdata;
   logic        h_err, h_ack, reg_we, reg_valid, cfg_run, stat_ready, stat_fault;
   logic [5:0]  reg_addr;

   logic        en2, hv2, ack2, rdy2;
   logic [15:0] h_rdata2, unused_wdata2;
   logic [5:0]  unused_addr2;
   logic        h_err2, h_ack2, unused_we2, reg_valid2, cfg_run2, stat_ready2, stat_fault2;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   localparam logic [5:0]  EA [4] = '{6'h00, 6'h1F, 6'h20, 6'h23};
   localparam logic [15:0] ED [4] = '{16'h0000, 16'h0000, 16'h1F40, 16'h0000};

   always #5 clk = ~clk;

   mc97_ctrl u_dut (
      .clk(clk), .rst(rst), .enable(enable),
      .h_addr(h_addr), .h_wdata(h_wdata), .h_we(h_we), .h_valid(h_valid),
      .h_rdata(h_rdata), .h_err(h_err), .h_ack(h_ack),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_valid(reg_valid),
      .reg_rdata(reg_rdata), .reg_rerr(reg_rerr), .reg_ack(reg_ack),
      .stat_codec_ready(stat_codec_ready),
      .cfg_run(cfg_run), .stat_ready(stat_ready), .stat_fault(stat_fault)
   );

   mc97_ctrl #(.TIMEOUT_W(6)) u_wd (
      .clk(clk), .rst(rst), .enable(en2),
      .h_addr(h_addr), .h_wdata(h_wdata), .h_we(h_we), .h_valid(hv2),
      .h_rdata(h_rdata2), .h_err(h_err2), .h_ack(h_ack2),
      .reg_addr(unused_addr2), .reg_wdata(unused_wdata2), .reg_we(unused_we2),
      .reg_valid(reg_valid2),
      .reg_rdata(reg_rdata), .reg_rerr(reg_rerr), .reg_ack(ack2),
      .stat_codec_ready(rdy2),
      .cfg_run(cfg_run2), .stat_ready(stat_ready2), .stat_fault(stat_fault2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Play the codec side of one register access: wait for reg_valid, check the request
   // stays stable for dly cycles, ack with the given read data, then check the drop.
   task automatic serve(input string tag, input logic [5:0] ea, input logic [15:0] ed,
                        input logic ewe, input int unsigned dly,
                        input logic [15:0] rd, input logic re);
      int unsigned n = 0;
      while (reg_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "/req"}, {8'h0, reg_valid, reg_addr, reg_wdata, reg_we}, {8'h0, 1'b1, ea, ed, ewe});
      for (int unsigned i = 1; i < dly; i++) begin
         tick();
         chk({tag, "/hold"}, {8'h0, reg_valid, reg_addr, reg_wdata, reg_we}, {8'h0, 1'b1, ea, ed, ewe});
      end
      reg_ack   = 1'b1;
      reg_rdata = rd;
      reg_rerr  = re;
      tick();
      reg_ack  = 1'b0;
      reg_rerr = 1'b0;
      chk({tag, "/drop"}, reg_valid, 1'b0);
   endtask

   // Host keeps h_valid one cycle past h_ack; no second ack and no new access may follow.
   task automatic host_done(input string tag);
      tick();
      chk({tag, "/ack_once"}, h_ack, 1'b0);
      chk({tag, "/no_reissue"}, reg_valid, 1'b0);
      h_valid = 1'b0;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      rst = 1'b1; enable = 1'b0; h_we = 1'b0; h_valid = 1'b0; h_addr = '0; h_wdata = '0;
      reg_rdata = '0; reg_rerr = 1'b0; reg_ack = 1'b0; stat_codec_ready = 1'b0;
      en2 = 1'b0; hv2 = 1'b0; ack2 = 1'b0; rdy2 = 1'b0;
      repeat (3) tick();
      chk("rst/cfg_run", cfg_run, 1'b0);
      chk("rst/reg_valid", reg_valid, 1'b0);
      chk("rst/h_ack", h_ack, 1'b0);
      chk("rst/h_err", h_err, 1'b0);
      chk("rst/h_rdata", h_rdata, 16'h0);
      chk("rst/stat_ready", stat_ready, 1'b0);
      chk("rst/stat_fault", stat_fault, 1'b0);
      rst = 1'b0;

      // Host access while OFF: error ack one cycle later, codec untouched.
      h_addr = 6'h10; h_we = 1'b0; h_valid = 1'b1;
      tick();
      chk("off/ack", h_ack, 1'b1);
      chk("off/err", h_err, 1'b1);
      chk("off/reg_valid", reg_valid, 1'b0);
      host_done("off");

      // Bring-up: codec ready after 100 cycles, acks 5 cycles after reg_valid.
      enable = 1'b1;
      tick();
      chk("up/cfg_run", cfg_run, 1'b1);
      repeat (99) tick();
      chk("up/no_issue", reg_valid, 1'b0);
      chk("up/not_ready", stat_ready, 1'b0);
      stat_codec_ready = 1'b1;
      for (int unsigned i = 0; i < 4; i++) serve("init", EA[i], ED[i], 1'b1, 5, 16'h0, 1'b0);
      chk("up/stat_ready", stat_ready, 1'b1);
      repeat (3) tick();
      chk("up/quiet", reg_valid, 1'b0);

      // Host read.
      h_addr = 6'h20; h_wdata = 16'h7777; h_we = 1'b0; h_valid = 1'b1;
      serve("rd", 6'h20, 16'h7777, 1'b0, 3, 16'h1F40, 1'b0);
      chk("rd/ack", h_ack, 1'b1);
      chk("rd/rdata", h_rdata, 16'h1F40);
      chk("rd/err", h_err, 1'b0);
      host_done("rd");

      // Host write: reg_rerr must not turn into h_err.
      h_addr = 6'h02; h_wdata = 16'hA5A5; h_we = 1'b1; h_valid = 1'b1;
      serve("wr", 6'h02, 16'hA5A5, 1'b1, 2, 16'hDEAD, 1'b1);
      chk("wr/ack", h_ack, 1'b1);
      chk("wr/err", h_err, 1'b0);
      host_done("wr");

`ifdef MC97_CTRL_RETRY_EN
      h_addr = 6'h26; h_wdata = 16'h0; h_we = 1'b0; h_valid = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         serve("rty", 6'h26, 16'h0, 1'b0, 2, 16'hBEEF, 1'b1);
         chk("rty/no_ack", h_ack, 1'b0);
      end
      serve("rty", 6'h26, 16'h0, 1'b0, 2, 16'h0042, 1'b0);
      chk("rty/ack", h_ack, 1'b1);
      chk("rty/err", h_err, 1'b0);
      chk("rty/rdata", h_rdata, 16'h0042);
      host_done("rty");
      h_valid = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         serve("rty5", 6'h26, 16'h0, 1'b0, 2, 16'hBEEF, 1'b1);
         chk("rty5/no_ack", h_ack, 1'b0);
      end
      serve("rty5", 6'h26, 16'h0, 1'b0, 2, 16'hBEEF, 1'b1);
      chk("rty5/ack", h_ack, 1'b1);
      chk("rty5/err", h_err, 1'b1);
      host_done("rty5");
`else
      h_addr = 6'h26; h_wdata = 16'h0; h_we = 1'b0; h_valid = 1'b1;
      serve("rderr", 6'h26, 16'h0, 1'b0, 2, 16'hBEEF, 1'b1);
      chk("rderr/ack", h_ack, 1'b1);
      chk("rderr/err", h_err, 1'b1);
      chk("rderr/rdata", h_rdata, 16'hBEEF);
      host_done("rderr");
`endif

      // Stray ack with nothing outstanding.
      reg_ack = 1'b1;
      tick();
      reg_ack = 1'b0;
      chk("stray/h_ack", h_ack, 1'b0);
      chk("stray/stat_ready", stat_ready, 1'b1);

      // Drain: enable drops while a host write is outstanding.
      h_addr = 6'h04; h_wdata = 16'h1234; h_we = 1'b1; h_valid = 1'b1;
      tick();
      chk("drain/issued", reg_valid, 1'b1);
      enable = 1'b0;
      tick();
      chk("drain/cfg_run", cfg_run, 1'b1);
      serve("drain", 6'h04, 16'h1234, 1'b1, 3, 16'h0, 1'b0);
      chk("drain/ack", h_ack, 1'b1);
      chk("drain/err", h_err, 1'b0);
      chk("drain/off", cfg_run, 1'b0);
      host_done("drain");

      // Reset during init entry 2, stray acks afterwards, init restarts at entry 0.
      enable = 1'b1;
      tick();
      tick();
      for (int unsigned i = 0; i < 2; i++) serve("pre", EA[i], ED[i], 1'b1, 2, 16'h0, 1'b0);
      for (int unsigned n = 0; n < 20 && reg_valid !== 1'b1; n++) tick();
      chk("pre/entry2", reg_addr, 6'h20);
      rst = 1'b1;
      tick();
      tick();
      chk("mid_rst/reg_valid", reg_valid, 1'b0);
      chk("mid_rst/cfg_run", cfg_run, 1'b0);
      rst = 1'b0;
      reg_ack = 1'b1;
      repeat (3) tick();
      reg_ack = 1'b0;
      for (int unsigned i = 0; i < 4; i++) serve("reinit", EA[i], ED[i], 1'b1, 2, 16'h0, 1'b0);
      chk("reinit/stat_ready", stat_ready, 1'b1);

      // Disable from IDLE with nothing outstanding.
      enable = 1'b0;
      tick();
      chk("idle_off/cfg_run", cfg_run, 1'b0);
      chk("idle_off/stat_ready", stat_ready, 1'b0);

      // Watchdog expiry in WAIT_RDY on the 6-bit instance.
      en2 = 1'b1;
      tick();
      chk("wd/cfg_run", cfg_run2, 1'b1);
      repeat (63) tick();
      chk("wd/not_yet", stat_fault2, 1'b0);
      tick();
      chk("wd/fault", stat_fault2, 1'b1);
      chk("wd/stat_ready", stat_ready2, 1'b0);
      hv2 = 1'b1;
      tick();
      chk("wd/h_ack", h_ack2, 1'b1);
      chk("wd/h_err", h_err2, 1'b1);
      chk("wd/reg_valid", reg_valid2, 1'b0);
      chk("wd/h_rdata", h_rdata2, 16'h0);
      hv2 = 1'b0;
      tick();
      chk("wd/ack_once", h_ack2, 1'b0);
      en2 = 1'b0;
      tick();
      chk("wd/off_fault", stat_fault2, 1'b0);
      chk("wd/off_run", cfg_run2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc97_ctrl.md
MC97_CTRL -- requirements
Module: mc97_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 20: width of the watchdog counter; an expiry occurs after 2^TIMEOUT_W-1 cycles.
REQ-002 SHALL have parameter RETRY_MAX, default 3: maximum number of read re-issues after a read error.
REQ-003 SHALL have ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  bring codec up (1) or down (0).
- h_addr  in  6  host register index.
- h_wdata  in  16  host write data.
- h_we  in  1  host write (1) or read (0).
- h_valid  in  1  host request.
- h_rdata  out  16  host read data.
- h_err  out  1  host access failed.
- h_ack  out  1  host completion pulse.
- reg_addr  out  6  to mc97.
- reg_wdata  out  16  to mc97.
- reg_we  out  1  to mc97.
- reg_valid  out  1  to mc97.
- reg_rdata  in  16  from mc97.
- reg_rerr  in  1  from mc97.
- reg_ack  in  1  from mc97.
- stat_codec_ready  in  1  from mc97.
- cfg_run  out  1  to mc97 frame-valid control.
- stat_ready  out  1  in IDLE.
- stat_fault  out  1  in FAULT.

Function
REQ-004 SHALL implement states OFF, WAIT_RDY, INIT, IDLE, HOST, DRAIN, FAULT.
REQ-005 SHALL move OFF->WAIT_RDY when enable=1; cfg_run SHALL be 1 in every state except OFF.
REQ-006 SHALL, in WAIT_RDY, go to INIT on stat_codec_ready=1, or to FAULT on watchdog expiry.
REQ-007 SHALL, in INIT, issue writes for init table entries 0..INIT_LEN-1 in order.
- Each entry is held on reg_* until reg_ack.
- The index advances on reg_ack.
- After the last ack the block goes to IDLE.
REQ-008 SHALL hold reg_valid, reg_addr, reg_wdata and reg_we stable from assertion until the cycle reg_ack=1, then deassert reg_valid in the next cycle.
REQ-009 SHALL, in IDLE with h_valid=1, latch h_addr, h_wdata and h_we in one cycle, assert reg_valid the next cycle and enter HOST.
REQ-010 SHALL, on reg_ack in HOST, produce a one-cycle h_ack.
- h_rdata = reg_rdata captured on the ack cycle.
- h_err = reg_rerr for reads, 0 for writes.
- Return to IDLE.
REQ-011 SHALL ignore a new h_valid until h_ack has been issued for the previous request; the host holds h_valid until h_ack.
REQ-012 SHALL, while in OFF or FAULT with h_valid=1, return h_ack with h_err=1 one cycle later without touching reg_*.
REQ-013 SHALL restart the watchdog on every state entry and every reg_ack.
REQ-014 SHALL handle watchdog expiry with reg_valid=1 as follows:
- Drop reg_valid.
- In INIT, go to FAULT.
- In HOST, issue h_ack with h_err=1 and go to IDLE.
REQ-015 SHALL ignore a reg_ack that arrives while reg_valid=0.
REQ-016 SHALL handle enable=0 as follows:
- With reg_valid=0, go to OFF next cycle.
- With reg_valid=1, go to DRAIN and complete the access, including h_ack for a host access, then go to OFF.
- DRAIN SHALL also exit to OFF on watchdog expiry.
REQ-017 SHALL, on re-entry to INIT, restart the init index at 0.
REQ-018 SHALL, if reg_ack and watchdog expiry occur in the same cycle, honour reg_ack.

Reset
REQ-019 SHALL, on rst, enter OFF with:
- cfg_run=0, reg_valid=0, h_ack=0, h_err=0.
- h_rdata=0, stat_ready=0, stat_fault=0.
- Init index=0, retry count=0, watchdog=0.
REQ-020 SHALL abandon any access in flight on rst; the first reg_ack seen afterwards falls under REQ-015.

Configuration
REQ-021 SHALL, with MC97_CTRL_RETRY_EN defined:
- On a HOST read ack with reg_rerr=1 and retry count < RETRY_MAX, re-issue the same read (reg_valid one cycle after the ack) without h_ack, and increment the retry count.
- The retry count clears on each new host request.
REQ-022 SHALL, without MC97_CTRL_RETRY_EN, complete on the first ack with h_err=reg_rerr; no retry logic is present.

Structure
REQ-023 SHALL place the state enum, INIT_LEN=4 and the init entry constants in package mc97_ctrl_pkg.
REQ-024 SHALL use sub-module mc97_ctrl_init_rom: combinational index -> {addr[5:0], data[15:0]} with these entries:
- 0: 0x00/0x0000
- 1: 0x1F/0x0000
- 2: 0x20/0x1F40
- 3: 0x23/0x0000

Verification
REQ-025 Bring-up: enable=1, stat_codec_ready=1 after 100 cycles, every reg_ack 5 cycles after reg_valid -> four writes in table order, then stat_ready=1.
REQ-026 Host read: IDLE, h_addr=0x20, h_we=0; mc97 acks with reg_rdata=0x1F40, reg_rerr=0 -> single h_ack, h_rdata=0x1F40, h_err=0.
REQ-027 Retry (RETRY_EN): three acks with reg_rerr=1, then a fourth with reg_rerr=0 -> four reg_valid pulses, one h_ack, h_err=0; five consecutive errors -> h_ack after the fourth ack with h_err=1.
REQ-028 Timeout: TIMEOUT_W=6, stat_codec_ready held at 0 -> FAULT after 63 cycles with stat_fault=1; a host read then gives h_ack next cycle with h_err=1.
REQ-029 Drain: enable drops while a host write is outstanding -> reg_* stable until reg_ack, then h_ack, then OFF with cfg_run=0.
REQ-030 Reset mid-INIT: rst during entry 2, then enable=1 with codec ready -> a stray reg_ack is ignored and init restarts at entry 0.
